// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp controller and its phase counter.
package pwm_pkg;

  localparam int COUNTER_WIDTH_DEF = 8;
  localparam int PERIOD_RST_DEF    = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RAMP = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_phase_counter.sv
// Free-running 0..period phase counter mirroring the PWM generator's count;
// held at 0 while disabled, flags the last cycle of each period.
module pwm_phase_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] phase,
  output logic             boundary
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (!enable) begin
      phase <= '0;
    end else if (phase < period) begin
      phase <= phase + 1'b1;
    end else begin
      phase <= '0;
    end
  end

  assign boundary = enable & (phase == period);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/retarget controller feeding a PWM generator's period and duty.
// Optional sticky done interrupt (irq/irq_clr) when PWM_RAMP_IRQ_EN is defined.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int PERIOD_RST    = PERIOD_RST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [COUNTER_WIDTH-1:0] cfg_period,
  input  logic [COUNTER_WIDTH-1:0] cfg_duty,
  input  logic [COUNTER_WIDTH-1:0] cfg_step,
  output logic [COUNTER_WIDTH-1:0] duty_cycle,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic                     period_tick,
  output logic                     busy,
  output logic                     done
`ifdef PWM_RAMP_IRQ_EN
  ,
  input  logic                     irq_clr,
  output logic                     irq
`endif
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  ramp_state_e state, state_next;
  cnt_t        duty_q, duty_next;
  cnt_t        period_q, period_next;
  cnt_t        tgt_period, tgt_duty, tgt_step;
  cnt_t        stepped;
  cnt_t        unused_phase;
  logic        done_q, done_next;
  logic        accept;
  logic        boundary;

  // One bounded move toward the target; clamps onto it instead of overshooting.
  function automatic cnt_t ramp_step(input cnt_t d, input cnt_t tgt, input cnt_t stp);
    cnt_t diff;
    if (stp == '0) begin
      return tgt;
    end else if (tgt >= d) begin
      diff = tgt - d;
      return (diff <= stp) ? tgt : cnt_t'(d + stp);
    end else begin
      diff = d - tgt;
      return (diff <= stp) ? tgt : cnt_t'(d - stp);
    end
  endfunction

  pwm_phase_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_phase (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .period  (period_q),
    .phase   (unused_phase),
    .boundary(boundary)
  );

  assign stepped = ramp_step(duty_q, tgt_duty, tgt_step);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    duty_next   = duty_q;
    period_next = period_q;
    done_next   = 1'b0;
    accept      = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      duty_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            accept     = 1'b1;
            state_next = ARM;
          end
        end
        ARM: begin
          if (boundary) begin
            period_next = tgt_period;
            duty_next   = stepped;
            if (stepped == tgt_duty) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = RAMP;
            end
          end
        end
        RAMP: begin
          if (boundary) begin
            duty_next = stepped;
            if (stepped == tgt_duty) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      duty_q   <= '0;
      period_q <= cnt_t'(PERIOD_RST);
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      duty_q   <= duty_next;
      period_q <= period_next;
      done_q   <= done_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_period <= '0;
      tgt_duty   <= '0;
      tgt_step   <= '0;
    end else if (accept) begin
      tgt_period <= cfg_period;
      tgt_duty   <= cfg_duty;
      tgt_step   <= cfg_step;
    end
  end

`ifdef PWM_RAMP_IRQ_EN
  // Set has priority over a coincident clear so a completion is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= done_q | (irq & ~irq_clr);
    end
  end
`endif

  assign cfg_ready   = (state == IDLE) & enable;
  assign busy        = (state == ARM) | (state == RAMP);
  assign duty_cycle  = duty_q;
  assign period      = period_q;
  assign period_tick = boundary;
  assign done        = done_q;

endmodule
